multicycle_controller: RTL and testbench
========================================

# multicycle_controller

Moore-style multicycle control FSM for the RV32I core. It sequences the shared datapath (ALU, register file, immediate extend unit, and the unified cache port) one instruction at a time. It also produces the extend unit's `ImmSrc` select from the latched opcode. Every memory access is a request/ready handshake with the cache, so a miss stalls the FSM in place.

## Interface
Parameters:
- none. All encodings are constants in the shared package.

Ports:
- `clk`  in  1  single clock, rising-edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `op`  in  7  Instr[6:0] from the instruction register.
- `funct3`  in  3  Instr[14:12].
- `funct7b5`  in  1  Instr[30].
- `Zero`  in  1  ALU zero flag.
- `MemReady`  in  1  cache has completed the current read/write this cycle.
- `MemRead`  out  1  cache read request.
- `MemWrite`  out  1  cache write request.
- `AdrSrc`  out  1  0 = PC, 1 = ALU result register.
- `IRWrite`  out  1  load instruction register and OldPC.
- `PCWrite`  out  1  PC enable.
- `RegWrite`  out  1  register-file write enable.
- `ResultSrc`  out  2  00 = ALUOut, 01 = Data, 10 = ALUResult.
- `ALUSrcA`  out  2  00 = PC, 01 = OldPC, 10 = rs1.
- `ALUSrcB`  out  2  00 = rs2, 01 = ImmExt, 10 = constant 4.
- `ALUControl`  out  3  000 add, 001 sub, 010 and, 011 or, 101 slt.
- `ImmSrc`  out  2  to extend unit: 00 I, 01 S, 10 B, 11 J.

## Operation
States (4-bit): FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECUTER, EXECUTEI, ALUWB, BEQ, JAL.

Per-state outputs. Any signal not listed is 0 or 00.
- FETCH: MemRead, AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10. IRWrite and PCWrite are asserted only when MemReady=1. The FSM stays in FETCH while MemReady=0 and moves to DECODE when it is 1.
- DECODE: ALUSrcA=01, ALUSrcB=01, ALUOp=00, which precomputes the branch/jal target. Next state by `op`:
  - 0000011 or 0100011 → MEMADR
  - 0110011 → EXECUTER
  - 0010011 → EXECUTEI
  - 1100011 → BEQ
  - 1101111 → JAL
  - any other opcode → FETCH (executed as a NOP, no side effects)
- MEMADR: ALUSrcA=10, ALUSrcB=01, ALUOp=00. Goes to MEMREAD if op[5]=0, otherwise MEMWRITE.
- MEMREAD: MemRead, AdrSrc=1. Holds until MemReady, then goes to MEMWB.
- MEMWB: ResultSrc=01, RegWrite. Goes to FETCH.
- MEMWRITE: MemWrite, AdrSrc=1. Holds until MemReady, then goes to FETCH.
- EXECUTER: ALUSrcA=10, ALUSrcB=00, ALUOp=10. Goes to ALUWB.
- EXECUTEI: ALUSrcA=10, ALUSrcB=01, ALUOp=10. Goes to ALUWB.
- ALUWB: ResultSrc=00, RegWrite. Goes to FETCH.
- BEQ: ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00, Branch. Goes to FETCH.
- JAL: ALUSrcA=01, ALUSrcB=10, ALUOp=00, ResultSrc=00, PCUpdate. Goes to ALUWB.

Derived signals:
- `PCWrite` = (FETCH & MemReady) | PCUpdate | (Branch & Zero).
- `ImmSrc` is combinational from `op` in every state: 0100011 → 01, 1100011 → 10, 1101111 → 11, anything else → 00.

ALU decode:
- ALUOp 00 → add.
- ALUOp 01 → sub.
- ALUOp 10, by funct3:
  - 000 → sub if (op[5] & funct7b5), else add
  - 010 → slt
  - 110 → or
  - 111 → and
  - any other funct3 → add

## Timing
- State register updates on the rising edge of `clk`. All outputs are combinational from state, `op`, `funct3`, `funct7b5`, `Zero` and `MemReady`.
- Reset:
  - `rst_n`=0 at an edge forces the state to FETCH.
  - While `rst_n`=0, MemRead, MemWrite, IRWrite, PCWrite and RegWrite are forced to 0.
  - All mux selects show their FETCH values.
  - Reset in the middle of an instruction abandons it. No partial RegWrite occurs after reset is released.
- Handshake:
  - A request (MemRead or MemWrite) stays asserted and stable until the cycle in which MemReady=1. The FSM leaves the state in that same cycle.
  - MemReady is ignored in states that make no request.
- Cycle counts with zero wait: lw 5, sw 4, R-type 4, I-type 4, beq 3, jal 4. Each cache wait cycle adds 1 in FETCH, MEMREAD or MEMWRITE.
- Simultaneous events: if MemReady and reset arrive in the same cycle, reset wins and IRWrite/PCWrite stay 0.

## Structure
- Package `riscv_ctrl_pkg` holds:
  - state encodings
  - opcode constants (LW, SW, RTYPE, ITYPE, BEQ, JAL)
  - ImmSrc, ResultSrc, ALUSrcA/B and ALUControl codes
- Sub-module `alu_decoder` holds the ALUOp/funct3/funct7b5/op[5] → ALUControl logic.
- Top level = state register + next-state logic + output decode.

## Test plan
- Reset, then `add x3,x1,x2` (op 0110011, f3 000, f7b5 0) with MemReady=1: states FETCH, DECODE, EXECUTER, ALUWB, FETCH. ALUControl=000 in EXECUTER; RegWrite=1 only in ALUWB.
- lw (0000011) with MemReady low for 3 cycles in MEMREAD:
  - MemRead and AdrSrc=1 held for 4 cycles, then MEMWB with ResultSrc=01 and RegWrite.
  - Total 8 cycles.
- sw (0100011): ImmSrc=01 throughout, MemWrite asserted in MEMWRITE until MemReady, no RegWrite at any point.
- beq (1100011): with Zero=1, PCWrite=1 in BEQ and ALUControl=001; with Zero=0, PCWrite=0. 3 cycles each.
- jal (1101111): ImmSrc=11, PCWrite=1 in JAL, then ALUWB with RegWrite. Unknown opcode 0001111 returns to FETCH from DECODE with no strobes.
- `rst_n`=0 asserted during MEMREAD with MemReady=1: next state FETCH, all strobes 0 while reset is low, no RegWrite afterwards.

Source files
------------

// File: rtl/riscv_ctrl_pkg.sv
// Shared encodings for the RV32I multicycle control path: FSM states, opcodes,
// datapath mux selects and ALU operation codes.
package riscv_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTER = 4'd6,
        S_EXECUTEI = 4'd7,
        S_ALUWB    = 4'd8,
        S_BEQ      = 4'd9,
        S_JAL      = 4'd10
    } state_t;

    localparam logic [6:0] OP_LW    = 7'b0000011;
    localparam logic [6:0] OP_SW    = 7'b0100011;
    localparam logic [6:0] OP_RTYPE = 7'b0110011;
    localparam logic [6:0] OP_ITYPE = 7'b0010011;
    localparam logic [6:0] OP_BEQ   = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;

    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    // Immediate format is a pure function of the opcode, independent of state.
    function automatic logic [1:0] immSrcFor(input logic [6:0] op);
        case (op)
            OP_SW:   return IMM_S;
            OP_BEQ:  return IMM_B;
            OP_JAL:  return IMM_J;
            default: return IMM_I;
        endcase
    endfunction

endpackage

// File: rtl/alu_decoder.sv
// Maps the FSM's coarse ALUOp plus instruction funct fields onto the ALU's
// operation select.
module alu_decoder
    import riscv_ctrl_pkg::*;
(
    input  logic [1:0] aluOp,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       op5,
    output logic [2:0] aluControl
);

    // Only R-type (op[5]=1) with funct7b5 set means sub; addi ignores bit 30.
    always_comb begin
        aluControl = ALU_ADD;
        case (aluOp)
            ALUOP_ADD: aluControl = ALU_ADD;
            ALUOP_SUB: aluControl = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct3)
                    3'b000:  aluControl = (op5 & funct7b5) ? ALU_SUB : ALU_ADD;
                    3'b010:  aluControl = ALU_SLT;
                    3'b110:  aluControl = ALU_OR;
                    3'b111:  aluControl = ALU_AND;
                    default: aluControl = ALU_ADD;
                endcase
            end
            default: aluControl = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Moore-style multicycle control FSM for the RV32I core; sequences the shared
// datapath and stalls on the cache request/ready handshake.
module multicycle_controller
    import riscv_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       Zero,
    input  logic       MemReady,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       AdrSrc,
    output logic       IRWrite,
    output logic       PCWrite,
    output logic       RegWrite,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [2:0] ALUControl,
    output logic [1:0] ImmSrc
);

    state_t     state;
    state_t     nextState;
    state_t     decState;
    logic [1:0] aluOp;
    logic       memReadRaw;
    logic       memWriteRaw;
    logic       regWriteRaw;
    logic       fetchAck;
    logic       branch;
    logic       pcUpdate;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_FETCH;
        end else begin
            state <= nextState;
        end
    end

    // While reset is held the outputs decode as FETCH so every mux select
    // already shows its fetch value; the strobes are gated separately below.
    always_comb begin
        decState    = rst_n ? state : S_FETCH;
        nextState   = S_FETCH;
        memReadRaw  = 1'b0;
        memWriteRaw = 1'b0;
        regWriteRaw = 1'b0;
        fetchAck    = 1'b0;
        branch      = 1'b0;
        pcUpdate    = 1'b0;
        AdrSrc      = 1'b0;
        ResultSrc   = RES_ALUOUT;
        ALUSrcA     = SRCA_PC;
        ALUSrcB     = SRCB_RS2;
        aluOp       = ALUOP_ADD;
        case (decState)
            S_FETCH: begin
                memReadRaw = 1'b1;
                fetchAck   = MemReady;
                ALUSrcA    = SRCA_PC;
                ALUSrcB    = SRCB_FOUR;
                ResultSrc  = RES_ALURESULT;
                nextState  = MemReady ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                ALUSrcA = SRCA_OLDPC;
                ALUSrcB = SRCB_IMM;
                case (op)
                    OP_LW, OP_SW: nextState = S_MEMADR;
                    OP_RTYPE:     nextState = S_EXECUTER;
                    OP_ITYPE:     nextState = S_EXECUTEI;
                    OP_BEQ:       nextState = S_BEQ;
                    OP_JAL:       nextState = S_JAL;
                    default:      nextState = S_FETCH;
                endcase
            end
            S_MEMADR: begin
                ALUSrcA   = SRCA_RS1;
                ALUSrcB   = SRCB_IMM;
                nextState = op[5] ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                memReadRaw = 1'b1;
                AdrSrc     = 1'b1;
                nextState  = MemReady ? S_MEMWB : S_MEMREAD;
            end
            S_MEMWB: begin
                ResultSrc   = RES_DATA;
                regWriteRaw = 1'b1;
                nextState   = S_FETCH;
            end
            S_MEMWRITE: begin
                memWriteRaw = 1'b1;
                AdrSrc      = 1'b1;
                nextState   = MemReady ? S_FETCH : S_MEMWRITE;
            end
            S_EXECUTER: begin
                ALUSrcA   = SRCA_RS1;
                ALUSrcB   = SRCB_RS2;
                aluOp     = ALUOP_FUNCT;
                nextState = S_ALUWB;
            end
            S_EXECUTEI: begin
                ALUSrcA   = SRCA_RS1;
                ALUSrcB   = SRCB_IMM;
                aluOp     = ALUOP_FUNCT;
                nextState = S_ALUWB;
            end
            S_ALUWB: begin
                ResultSrc   = RES_ALUOUT;
                regWriteRaw = 1'b1;
                nextState   = S_FETCH;
            end
            S_BEQ: begin
                ALUSrcA   = SRCA_RS1;
                ALUSrcB   = SRCB_RS2;
                aluOp     = ALUOP_SUB;
                branch    = 1'b1;
                nextState = S_FETCH;
            end
            S_JAL: begin
                ALUSrcA   = SRCA_OLDPC;
                ALUSrcB   = SRCB_FOUR;
                pcUpdate  = 1'b1;
                nextState = S_ALUWB;
            end
            default: nextState = S_FETCH;
        endcase
    end

    // Reset overrides every strobe, including a same-cycle MemReady in FETCH.
    assign MemRead  = memReadRaw & rst_n;
    assign MemWrite = memWriteRaw & rst_n;
    assign RegWrite = regWriteRaw & rst_n;
    assign IRWrite  = fetchAck & rst_n;
    assign PCWrite  = (fetchAck | pcUpdate | (branch & Zero)) & rst_n;
    assign ImmSrc   = immSrcFor(op);

    alu_decoder u_alu_decoder (
        .aluOp      (aluOp),
        .funct3     (funct3),
        .funct7b5   (funct7b5),
        .op5        (op[5]),
        .aluControl (ALUControl)
    );

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed, table-driven bench for multicycle_controller: one vector per clock
// cycle, followed by a hand-run store with a long cache stall.
module tb_multicycle_controller;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       Zero;
    logic       MemReady;
    logic       MemRead;
    logic       MemWrite;
    logic       AdrSrc;
    logic       IRWrite;
    logic       PCWrite;
    logic       RegWrite;
    logic [1:0] ResultSrc;
    logic [1:0] ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [2:0] ALUControl;
    logic [1:0] ImmSrc;

    typedef struct packed {
        logic       mr;
        logic       mw;
        logic       adr;
        logic       irw;
        logic       pcw;
        logic       rw;
        logic [1:0] res;
        logic [1:0] sa;
        logic [1:0] sb;
        logic [2:0] alu;
        logic [1:0] imm;
    } ctrl_t;

    typedef struct {
        logic       rstn;
        logic [6:0] op;
        logic [2:0] f3;
        logic       f7;
        logic       z;
        logic       rdy;
        ctrl_t      exp;
        string      name;
    } vec_t;

    localparam logic [6:0] R  = 7'b0110011;
    localparam logic [6:0] I  = 7'b0010011;
    localparam logic [6:0] LW = 7'b0000011;
    localparam logic [6:0] SW = 7'b0100011;
    localparam logic [6:0] BQ = 7'b1100011;
    localparam logic [6:0] J  = 7'b1101111;
    localparam logic [6:0] U  = 7'b0001111;

    int checks = 0;
    int errors = 0;
    vec_t vecs[$];

    multicycle_controller dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .op         (op),
        .funct3     (funct3),
        .funct7b5   (funct7b5),
        .Zero       (Zero),
        .MemReady   (MemReady),
        .MemRead    (MemRead),
        .MemWrite   (MemWrite),
        .AdrSrc     (AdrSrc),
        .IRWrite    (IRWrite),
        .PCWrite    (PCWrite),
        .RegWrite   (RegWrite),
        .ResultSrc  (ResultSrc),
        .ALUSrcA    (ALUSrcA),
        .ALUSrcB    (ALUSrcB),
        .ALUControl (ALUControl),
        .ImmSrc     (ImmSrc)
    );

    always #5 clk = ~clk;

    // Hand-encoded expected output words, one per FSM state.
    function automatic ctrl_t eRst(input logic [1:0] imm);
        return '{mr:0, mw:0, adr:0, irw:0, pcw:0, rw:0, res:2'b10, sa:2'b00, sb:2'b10, alu:3'b000, imm:imm};
    endfunction
    function automatic ctrl_t eFetch(input logic rdy, input logic [1:0] imm);
        return '{mr:1, mw:0, adr:0, irw:rdy, pcw:rdy, rw:0, res:2'b10, sa:2'b00, sb:2'b10, alu:3'b000, imm:imm};
    endfunction
    function automatic ctrl_t eDec(input logic [1:0] imm);
        return '{mr:0, mw:0, adr:0, irw:0, pcw:0, rw:0, res:2'b00, sa:2'b01, sb:2'b01, alu:3'b000, imm:imm};
    endfunction
    function automatic ctrl_t eMemAdr(input logic [1:0] imm);
        return '{mr:0, mw:0, adr:0, irw:0, pcw:0, rw:0, res:2'b00, sa:2'b10, sb:2'b01, alu:3'b000, imm:imm};
    endfunction
    function automatic ctrl_t eMemRd();
        return '{mr:1, mw:0, adr:1, irw:0, pcw:0, rw:0, res:2'b00, sa:2'b00, sb:2'b00, alu:3'b000, imm:2'b00};
    endfunction
    function automatic ctrl_t eMemWb();
        return '{mr:0, mw:0, adr:0, irw:0, pcw:0, rw:1, res:2'b01, sa:2'b00, sb:2'b00, alu:3'b000, imm:2'b00};
    endfunction
    function automatic ctrl_t eMemWr();
        return '{mr:0, mw:1, adr:1, irw:0, pcw:0, rw:0, res:2'b00, sa:2'b00, sb:2'b00, alu:3'b000, imm:2'b01};
    endfunction
    function automatic ctrl_t eExR(input logic [2:0] alu);
        return '{mr:0, mw:0, adr:0, irw:0, pcw:0, rw:0, res:2'b00, sa:2'b10, sb:2'b00, alu:alu, imm:2'b00};
    endfunction
    function automatic ctrl_t eExI(input logic [2:0] alu);
        return '{mr:0, mw:0, adr:0, irw:0, pcw:0, rw:0, res:2'b00, sa:2'b10, sb:2'b01, alu:alu, imm:2'b00};
    endfunction
    function automatic ctrl_t eWb(input logic [1:0] imm);
        return '{mr:0, mw:0, adr:0, irw:0, pcw:0, rw:1, res:2'b00, sa:2'b00, sb:2'b00, alu:3'b000, imm:imm};
    endfunction
    function automatic ctrl_t eBeq(input logic z);
        return '{mr:0, mw:0, adr:0, irw:0, pcw:z, rw:0, res:2'b00, sa:2'b10, sb:2'b00, alu:3'b001, imm:2'b10};
    endfunction
    function automatic ctrl_t eJal();
        return '{mr:0, mw:0, adr:0, irw:0, pcw:1, rw:0, res:2'b00, sa:2'b01, sb:2'b10, alu:3'b000, imm:2'b11};
    endfunction

    function automatic void addVec(input logic rstn, input logic [6:0] o, input logic [2:0] f3,
                                   input logic f7, input logic z, input logic rdy,
                                   input ctrl_t e, input string n);
        vec_t v;
        v.rstn = rstn; v.op = o; v.f3 = f3; v.f7 = f7; v.z = z; v.rdy = rdy;
        v.exp = e; v.name = n;
        vecs.push_back(v);
    endfunction

    // Four-cycle ALU instruction: FETCH, DECODE, EXECUTE, ALUWB.
    function automatic void addAluInstr(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                                        input logic [2:0] alu, input string n);
        addVec(1, o, f3, f7, 0, 1, eFetch(1, 2'b00), {n, "_fetch"});
        addVec(1, o, f3, f7, 0, 1, eDec(2'b00), {n, "_decode"});
        addVec(1, o, f3, f7, 0, 0, (o == R) ? eExR(alu) : eExI(alu), {n, "_exec"});
        addVec(1, o, f3, f7, 0, 0, eWb(2'b00), {n, "_aluwb"});
    endfunction

    function automatic ctrl_t sampleOutputs();
        return '{mr:MemRead, mw:MemWrite, adr:AdrSrc, irw:IRWrite, pcw:PCWrite, rw:RegWrite,
                 res:ResultSrc, sa:ALUSrcA, sb:ALUSrcB, alu:ALUControl, imm:ImmSrc};
    endfunction

    task automatic applyStimulus(input vec_t v);
        rst_n    = v.rstn;
        op       = v.op;
        funct3   = v.f3;
        funct7b5 = v.f7;
        Zero     = v.z;
        MemReady = v.rdy;
    endtask

    task automatic checkOutput(input string n, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", n, actual, expected);
        end
    endtask

    initial begin
        int   cycles;
        int   stalls;
        logic sawRegWrite;
        logic immOk;
        logic done;

        rst_n = 1'b0; op = R; funct3 = 3'b000; funct7b5 = 1'b0; Zero = 1'b0; MemReady = 1'b0;

        // Reset, including MemReady=1 under reset in FETCH.
        addVec(0, R, 3'b000, 0, 0, 1, eRst(2'b00), "reset_rdy");
        addVec(0, R, 3'b000, 0, 0, 0, eRst(2'b00), "reset_hold");
        addAluInstr(R, 3'b000, 0, 3'b000, "add");
        addAluInstr(R, 3'b000, 1, 3'b001, "sub");
        addAluInstr(I, 3'b000, 1, 3'b000, "addi_f7");
        addAluInstr(I, 3'b010, 0, 3'b101, "slti");
        addAluInstr(R, 3'b110, 0, 3'b011, "or");
        addAluInstr(R, 3'b111, 0, 3'b010, "and");
        addAluInstr(I, 3'b100, 0, 3'b000, "xori_dflt");
        // lw with a fetch wait and three MEMREAD wait cycles.
        addVec(1, LW, 3'b010, 0, 0, 0, eFetch(0, 2'b00), "lw_fetch_wait");
        addVec(1, LW, 3'b010, 0, 0, 1, eFetch(1, 2'b00), "lw_fetch");
        addVec(1, LW, 3'b010, 0, 0, 1, eDec(2'b00), "lw_decode");
        addVec(1, LW, 3'b010, 0, 0, 1, eMemAdr(2'b00), "lw_memadr");
        addVec(1, LW, 3'b010, 0, 0, 0, eMemRd(), "lw_memread_w0");
        addVec(1, LW, 3'b010, 0, 0, 0, eMemRd(), "lw_memread_w1");
        addVec(1, LW, 3'b010, 0, 0, 0, eMemRd(), "lw_memread_w2");
        addVec(1, LW, 3'b010, 0, 0, 1, eMemRd(), "lw_memread_rdy");
        addVec(1, LW, 3'b010, 0, 0, 1, eMemWb(), "lw_memwb");
        // sw with one MEMWRITE wait.
        addVec(1, SW, 3'b010, 0, 0, 1, eFetch(1, 2'b01), "sw_fetch");
        addVec(1, SW, 3'b010, 0, 0, 1, eDec(2'b01), "sw_decode");
        addVec(1, SW, 3'b010, 0, 0, 1, eMemAdr(2'b01), "sw_memadr");
        addVec(1, SW, 3'b010, 0, 0, 0, eMemWr(), "sw_memwrite_w");
        addVec(1, SW, 3'b010, 0, 0, 1, eMemWr(), "sw_memwrite_rdy");
        // beq taken / not taken; Zero in DECODE must not write the PC.
        addVec(1, BQ, 3'b000, 0, 1, 1, eFetch(1, 2'b10), "beqt_fetch");
        addVec(1, BQ, 3'b000, 0, 1, 1, eDec(2'b10), "beqt_decode");
        addVec(1, BQ, 3'b000, 0, 1, 1, eBeq(1), "beqt_beq");
        addVec(1, BQ, 3'b000, 0, 0, 1, eFetch(1, 2'b10), "beqn_fetch");
        addVec(1, BQ, 3'b000, 0, 0, 1, eDec(2'b10), "beqn_decode");
        addVec(1, BQ, 3'b000, 0, 0, 1, eBeq(0), "beqn_beq");
        // jal
        addVec(1, J, 3'b000, 0, 0, 1, eFetch(1, 2'b11), "jal_fetch");
        addVec(1, J, 3'b000, 0, 0, 1, eDec(2'b11), "jal_decode");
        addVec(1, J, 3'b000, 0, 0, 1, eJal(), "jal_jal");
        addVec(1, J, 3'b000, 0, 0, 1, eWb(2'b11), "jal_aluwb");
        // Unknown opcode falls back to FETCH straight from DECODE.
        addVec(1, U, 3'b000, 0, 0, 1, eFetch(1, 2'b00), "unk_fetch");
        addVec(1, U, 3'b000, 0, 0, 1, eDec(2'b00), "unk_decode");
        addVec(1, U, 3'b000, 0, 0, 0, eFetch(0, 2'b00), "unk_back_fetch");
        // Reset in MEMREAD with MemReady: abandoned, no MEMWB afterwards.
        addVec(1, LW, 3'b010, 0, 0, 1, eFetch(1, 2'b00), "lwr_fetch");
        addVec(1, LW, 3'b010, 0, 0, 1, eDec(2'b00), "lwr_decode");
        addVec(1, LW, 3'b010, 0, 0, 1, eMemAdr(2'b00), "lwr_memadr");
        addVec(0, LW, 3'b010, 0, 0, 1, eRst(2'b00), "lwr_reset_in_memread");
        addVec(1, LW, 3'b010, 0, 0, 0, eFetch(0, 2'b00), "lwr_after_reset");
        addVec(1, LW, 3'b010, 0, 0, 0, eFetch(0, 2'b00), "lwr_after_reset2");

        foreach (vecs[i]) begin
            @(negedge clk);
            applyStimulus(vecs[i]);
            #2;
            checkOutput(vecs[i].name, int'(sampleOutputs()), int'(vecs[i].exp));
        end

        // Store with a five-cycle cache stall: 4 + 5 cycles, ImmSrc=S all along, no RegWrite.
        cycles = 0; stalls = 0; sawRegWrite = 1'b0; immOk = 1'b1; done = 1'b0;
        for (int k = 0; k < 30 && !done; k++) begin
            @(negedge clk);
            rst_n = 1'b1; op = SW; funct3 = 3'b010; funct7b5 = 1'b0; Zero = 1'b0; MemReady = 1'b1;
            #1;
            if (MemWrite && stalls < 5) begin
                MemReady = 1'b0;
                stalls++;
            end
            #1;
            if (RegWrite) sawRegWrite = 1'b1;
            if (ImmSrc != 2'b01) immOk = 1'b0;
            if (cycles > 0 && IRWrite) done = 1'b1;
            else cycles++;
        end
        checkOutput("sw_stall_done", int'(done), 1);
        checkOutput("sw_stall_cycles", cycles, 9);
        checkOutput("sw_stall_no_regwrite", int'(sawRegWrite), 0);
        checkOutput("sw_stall_immsrc", int'(immOk), 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
